scarv_cop_wbseq: RTL and testbench

SCARV_COP_WBSEQ -- requirements
Module: scarv_cop_wbseq

---
 rtl/scarv_cop_wbseq.sv | 172 +++++++++++++++++
 tb/tb_scarv_cop_wbseq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/scarv_cop_wbseq.sv
// Coprocessor writeback sequencer: queues up to two writes and splits 64-bit pair writes into two 32-bit register-file writes.
// Latency: the first write presents on crd_* in the cycle after the request is accepted; one 32-bit write per cycle after that.
// Backpressure: req_ready drops while two entries are queued. A pop does not free space for a request in the same cycle.
module scarv_cop_wbseq (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_addr,
    input  logic [3:0]  req_wen,
    input  logic        req_wide,
    input  logic [63:0] req_wdata,
    output logic [3:0]  crd_wen,
    output logic [3:0]  crd_addr,
    output logic [31:0] crd_wdata,
    output logic [15:0] pend_mask,
    output logic        busy
);

    // One queued writeback. For wide entries addr[0] is kept but never used.
    typedef struct packed {
        logic [3:0]  addr;
        logic [3:0]  wen;
        logic        wide;
        logic [63:0] data;
    } wb_ent_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } wb_state_t;

    wb_ent_t    ent_q [2];
    logic [1:0] vld_q;
    logic [1:0] vld_nxt;
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    wb_state_t  state_q;
    wb_state_t  state_nxt;

    wb_ent_t    head;
    wb_ent_t    new_ent;
    logic       push;
    logic       pop;
    logic       full;

    // Occupancy is the count of set valid bits, so "full" means both slots are valid.
    assign full      = &vld_q;
    assign req_ready = !full;
    assign busy      = |vld_q;
    assign head      = ent_q[rd_ptr_q];

    // Zero-enable requests are accepted but dropped; a flush blocks any enqueue that cycle.
    assign push = req_valid && req_ready && (req_wen != 4'b0000) && !flush;

    // The head leaves the queue once its last 32-bit half has been written.
    assign pop = ((state_q == ST_LO) && !head.wide) || (state_q == ST_HI);

    assign new_ent = '{addr: req_addr, wen: req_wen, wide: req_wide, data: req_wdata};

    // Valid bits after this cycle's push and pop. At occupancy 1 the two pointers differ, so the two updates touch different slots.
    always_comb begin
        vld_nxt = vld_q;
        if (pop) begin
            vld_nxt[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            vld_nxt[wr_ptr_q] = 1'b1;
        end
    end

    // Queue storage and pointers. Flush discards everything, including a half-written wide entry.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            vld_q    <= 2'b00;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else if (flush) begin
            vld_q    <= 2'b00;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            vld_q <= vld_nxt;
            if (push) begin
                ent_q[wr_ptr_q] <= new_ent;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
        end
    end

    // Drain FSM state register. Reset mid-pair abandons the HI half.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Drain FSM next state. Entering LO straight from a push gives the one-cycle write latency.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                state_nxt = push ? ST_LO : ST_IDLE;
            end
            ST_LO: begin
                if (head.wide) begin
                    state_nxt = ST_HI;
                end else begin
                    state_nxt = (|vld_nxt) ? ST_LO : ST_IDLE;
                end
            end
            ST_HI: begin
                state_nxt = (|vld_nxt) ? ST_LO : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (flush) begin
            state_nxt = ST_IDLE;
        end
    end

    // Write-port outputs. These depend only on the state register and the stored head, so req_* and flush have no combinational path to crd_*.
    always_comb begin
        crd_wen   = 4'b0000;
        crd_addr  = 4'd0;
        crd_wdata = 32'd0;
        case (state_q)
            ST_LO: begin
                crd_wen   = head.wen;
                crd_addr  = head.wide ? {head.addr[3:1], 1'b0} : head.addr;
                crd_wdata = head.data[31:0];
            end
            ST_HI: begin
                crd_wen   = head.wen;
                crd_addr  = {head.addr[3:1], 1'b1};
                crd_wdata = head.data[63:32];
            end
            default: begin
                crd_wen   = 4'b0000;
                crd_addr  = 4'd0;
                crd_wdata = 32'd0;
            end
        endcase
    end

    // Pending-register mask. A wide entry marks both registers of its pair until it pops, even after its LO half has been written.
    always_comb begin
        pend_mask = 16'd0;
        for (int i = 0; i < 2; i++) begin
            if (vld_q[i]) begin
                if (ent_q[i].wide) begin
                    pend_mask[{ent_q[i].addr[3:1], 1'b0}] = 1'b1;
                    pend_mask[{ent_q[i].addr[3:1], 1'b1}] = 1'b1;
                end else begin
                    pend_mask[ent_q[i].addr] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scarv_cop_wbseq.sv
// Bench for scarv_cop_wbseq: directed cases, then random traffic checked by a scoreboard.
// Every negedge, the monitor compares the DUT outputs with a model made of a pending-request list and a list of expected writes.
// The bench drives inputs 1ns after each posedge. It stops itself after a bounded drain.
module tb_scarv_cop_wbseq;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_addr = 4'd0;
    logic [3:0]  req_wen = 4'd0;
    logic        req_wide = 1'b0;
    logic [63:0] req_wdata = 64'd0;
    logic [3:0]  crd_wen;
    logic [3:0]  crd_addr;
    logic [31:0] crd_wdata;
    logic [15:0] pend_mask;
    logic        busy;

    scarv_cop_wbseq dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wen   (req_wen),
        .req_wide  (req_wide),
        .req_wdata (req_wdata),
        .crd_wen   (crd_wen),
        .crd_addr  (crd_addr),
        .crd_wdata (crd_wdata),
        .pend_mask (pend_mask),
        .busy      (busy)
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        logic [3:0] addr;
        logic       wide;
    } mdl_ent_t;

    typedef struct {
        logic [3:0]  addr;
        logic [3:0]  wen;
        logic [31:0] data;
        logic        last;
    } mdl_wr_t;

    mdl_ent_t ent_q[$];
    mdl_wr_t  wr_q[$];
    logic     mdl_ready = 1'b1;
    int       n_chk = 0;
    int       n_fail = 0;
    logic     accepted;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one cycle of inputs. At the edge, update the model: a flush clears it, an accepted nonzero-enable request adds its writes.
    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] w,
                        input logic wd, input logic [63:0] d, input logic fl);
        mdl_ent_t e;
        mdl_wr_t  x;
        req_valid = v;
        req_addr  = a;
        req_wen   = w;
        req_wide  = wd;
        req_wdata = d;
        flush     = fl;
        @(posedge g_clk);
        accepted = v && mdl_ready;
        if (fl) begin
            ent_q.delete();
            wr_q.delete();
        end else if (accepted && (w != 4'd0)) begin
            e.addr = a;
            e.wide = wd;
            ent_q.push_back(e);
            if (wd) begin
                x = '{addr: {a[3:1], 1'b0}, wen: w, data: d[31:0], last: 1'b0};
                wr_q.push_back(x);
                x = '{addr: {a[3:1], 1'b1}, wen: w, data: d[63:32], last: 1'b1};
                wr_q.push_back(x);
            end else begin
                x = '{addr: a, wen: w, data: d[31:0], last: 1'b1};
                wr_q.push_back(x);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 1'b0, 64'd0, 1'b0);
    endtask

    // Hold a request until it is accepted, giving up after 20 cycles.
    task automatic send(input logic [3:0] a, input logic [3:0] w, input logic wd, input logic [63:0] d);
        int tries = 0;
        accepted = 1'b0;
        while (!accepted && tries < 20) begin
            step(1'b1, a, w, wd, d, 1'b0);
            tries++;
        end
        if (!accepted) chk("send_timeout", 64'd0, 64'd1);
    endtask

    // Monitor: compare status against the pending list, then match any presented write with the head of the expected-write list.
    initial begin
        logic [15:0] exp_pend;
        mdl_wr_t     w;
        forever begin
            @(negedge g_clk);
            exp_pend = 16'd0;
            foreach (ent_q[i]) begin
                if (ent_q[i].wide) begin
                    exp_pend[{ent_q[i].addr[3:1], 1'b0}] = 1'b1;
                    exp_pend[{ent_q[i].addr[3:1], 1'b1}] = 1'b1;
                end else begin
                    exp_pend[ent_q[i].addr] = 1'b1;
                end
            end
            mdl_ready = (ent_q.size() < 2);
            chk("busy", {63'd0, busy}, {63'd0, ent_q.size() != 0});
            chk("req_ready", {63'd0, req_ready}, {63'd0, mdl_ready});
            chk("pend_mask", {48'd0, pend_mask}, {48'd0, exp_pend});
            if (wr_q.size() != 0) begin
                w = wr_q.pop_front();
                chk("crd_wen", {60'd0, crd_wen}, {60'd0, w.wen});
                chk("crd_addr", {60'd0, crd_addr}, {60'd0, w.addr});
                chk("crd_wdata", {32'd0, crd_wdata}, {32'd0, w.data});
                if (w.last) void'(ent_q.pop_front());
            end else begin
                chk("idle_wen", {60'd0, crd_wen}, 64'd0);
                chk("idle_addr", {60'd0, crd_addr}, 64'd0);
                chk("idle_wdata", {32'd0, crd_wdata}, 64'd0);
            end
        end
    end

    initial begin
        int budget;
        // Reset state is checked by the monitor while reset is held, including with req_valid high.
        req_valid = 1'b1;
        req_wen   = 4'hF;
        repeat (3) @(posedge g_clk);
        #1;
        req_valid = 1'b0;
        g_resetn  = 1'b1;
        idle(1);

        // Narrow write to register 5.
        send(4'd5, 4'hF, 1'b0, 64'h0000_0000_DEAD_BEEF);
        idle(3);
        // Wide write to the 6/7 pair; addr[0] is ignored.
        send(4'd7, 4'h3, 1'b1, 64'h1122_3344_5566_7788);
        idle(3);
        // Back-to-back writes with valid held high, filling the queue.
        send(4'd2, 4'hF, 1'b1, 64'hAAAA_0002_BBBB_0002);
        send(4'd9, 4'hC, 1'b0, 64'h0000_0000_CCCC_0009);
        send(4'd1, 4'h1, 1'b0, 64'h0000_0000_0000_0011);
        idle(6);
        // A zero-enable request is accepted but produces no write.
        send(4'd3, 4'h0, 1'b0, 64'h0000_0000_1234_5678);
        idle(2);
        // Flush during the LO cycle of a wide write to the 4/5 pair, with a request presented at the same time.
        send(4'd4, 4'hF, 1'b1, 64'h5555_5555_4444_4444);
        step(1'b1, 4'd8, 4'hF, 1'b0, 64'h88, 1'b1);
        idle(3);
        // Asynchronous reset in the HI cycle of a wide write.
        send(4'd10, 4'hF, 1'b1, 64'h0BAD_F00D_0A0A_0A0A);
        @(posedge g_clk);
        #2;
        g_resetn = 1'b0;
        ent_q.delete();
        wr_q.delete();
        #1;
        chk("rst_wen", {60'd0, crd_wen}, 64'd0);
        chk("rst_addr", {60'd0, crd_addr}, 64'd0);
        chk("rst_wdata", {32'd0, crd_wdata}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_pend", {48'd0, pend_mask}, 64'd0);
        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        @(posedge g_clk);
        @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        idle(3);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic        v;
            logic [3:0]  w;
            logic        fl;
            v  = ($urandom_range(0, 3) != 0);
            w  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            fl = ($urandom_range(0, 24) == 0);
            step(v, 4'($urandom), w, 1'($urandom), {$urandom, $urandom}, fl);
        end

        // Drain, with a bounded wait.
        budget = 0;
        while ((wr_q.size() != 0 || ent_q.size() != 0) && budget < 20) begin
            idle(1);
            budget++;
        end
        if (wr_q.size() != 0 || ent_q.size() != 0) chk("drain_timeout", 64'd0, 64'd1);
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
